// File: rtl/axi_arb_pkg.sv
// Shared types and AXI constants for the wrapperio_s_axi requester arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;

endpackage

// File: rtl/axi_wrapper_arbiter_if.sv
// AXI4 bundle carrying N lanes of AR/AW/W handshakes; R/B payload is shared across lanes.
interface axi_wrapper_arbiter_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N-1:0]          arvalid, arready;
  logic [N*ADDR_W-1:0]   araddr;
  logic [N*8-1:0]        arlen;
  logic [N*2-1:0]        arburst;
  logic [N-1:0]          rvalid, rlast, rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  logic [N-1:0]          awvalid, awready;
  logic [N*ADDR_W-1:0]   awaddr;
  logic [N*8-1:0]        awlen;
  logic [N*2-1:0]        awburst;
  logic [N-1:0]          wvalid, wready, wlast;
  logic [N*DATA_W-1:0]   wdata;
  logic [N*DATA_W/8-1:0] wstrb;
  logic [N-1:0]          bvalid, bready;
  logic [1:0]            bresp;

  modport master (
    output arvalid, araddr, arlen, arburst, input arready,
    input  rvalid, rlast, rdata, rresp, output rready,
    output awvalid, awaddr, awlen, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, output bready
  );

  modport slave (
    input  arvalid, araddr, arlen, arburst, output arready,
    output rvalid, rlast, rdata, rresp, input rready,
    input  awvalid, awaddr, awlen, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, input bready
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);
  int idx;

  // Scanning from the farthest candidate down lets the nearest one win by overwrite.
  always_comb begin
    gnt_idx = '0;
    idx     = 0;
    any     = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) gnt_idx = PTR_W'(idx);
    end
  end
endmodule

// File: rtl/axi_wrapper_arbiter.sv
// Shares one AXI4 slave port between NUM_REQ masters; read and write are arbitrated
// independently, round-robin, one burst in flight per direction.
module axi_wrapper_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  axi_wrapper_arbiter_if.slave  req,
  axi_wrapper_arbiter_if.master s_axi,
  output logic [2:0]            s_axi_arsize,
  output logic [2:0]            s_axi_awsize,
  output logic [3:0]            s_axi_arcache,
  output logic [3:0]            s_axi_awcache,
  output logic [2:0]            s_axi_arprot,
  output logic [2:0]            s_axi_awprot
);
  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_W / 8;
  typedef logic [PTR_W-1:0] ptr_t;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  assign s_axi_arsize  = 3'($clog2(STRB_W));
  assign s_axi_awsize  = 3'($clog2(STRB_W));
  assign s_axi_arcache = AXI_CACHE_DEF;
  assign s_axi_awcache = AXI_CACHE_DEF;
  assign s_axi_arprot  = 3'b000;
  assign s_axi_awprot  = 3'b000;

  // ---------------- read direction ----------------
  rd_state_t         rd_state, rd_nxt;
  ptr_t              rr_rd, rd_own, rd_gnt;
  logic              rd_any, ar_hs, r_done;
  logic [ADDR_W-1:0] ar_addr;
  logic [7:0]        ar_len;
  logic [1:0]        ar_burst;

  rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rd_pick (
    .req(req.arvalid), .ptr(rr_rd), .gnt_idx(rd_gnt), .any(rd_any)
  );

  assign ar_hs  = (rd_state == RD_ADDR) && s_axi.arready[0];
  assign r_done = (rd_state == RD_DATA) && s_axi.rvalid[0] && req.rready[rd_own] && s_axi.rlast[0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_nxt;
  end

  // NOTE: the default assignment on entry keeps every path assigned, so no latch is inferred.
  always_comb begin
    rd_nxt = rd_state;
    unique case (rd_state)
      RD_IDLE: if (rd_any) rd_nxt = RD_ADDR;
      RD_ADDR: if (ar_hs)  rd_nxt = RD_DATA;
      RD_DATA: if (r_done) rd_nxt = RD_IDLE;
      default: rd_nxt = RD_IDLE;
    endcase
  end

  // NOTE: these are a handful of flops, not a memory, so all of them take a reset value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_rd    <= '0;
      rd_own   <= '0;
      ar_addr  <= '0;
      ar_len   <= '0;
      ar_burst <= '0;
    end else begin
      if (rd_state == RD_IDLE && rd_any) begin
        rd_own   <= rd_gnt;
        ar_addr  <= req.araddr[int'(rd_gnt)*ADDR_W +: ADDR_W];
        ar_len   <= req.arlen[int'(rd_gnt)*8 +: 8];
        ar_burst <= req.arburst[int'(rd_gnt)*2 +: 2];
      end
      if (r_done) rr_rd <= ptr_inc(rd_own);
    end
  end

  always_comb begin
    s_axi.arvalid = '0;
    s_axi.araddr  = ar_addr;
    s_axi.arlen   = ar_len;
    s_axi.arburst = ar_burst;
    s_axi.rready  = '0;
    req.arready   = '0;
    req.rvalid    = '0;
    req.rlast     = '0;
    req.rdata     = s_axi.rdata;
    req.rresp     = s_axi.rresp;
    unique case (rd_state)
      RD_ADDR: begin
        s_axi.arvalid       = 1'b1;
        req.arready[rd_own] = s_axi.arready[0];
      end
      RD_DATA: begin
        req.rvalid[rd_own] = s_axi.rvalid[0];
        req.rlast[rd_own]  = s_axi.rlast[0];
        s_axi.rready[0]    = req.rready[rd_own];
      end
      default: ;
    endcase
  end

  // ---------------- write direction ----------------
  wr_state_t         wr_state, wr_nxt;
  ptr_t              rr_wr, wr_own, wr_gnt;
  logic              wr_any, aw_hs, w_done, b_done;
  logic [ADDR_W-1:0] aw_addr;
  logic [7:0]        aw_len;
  logic [1:0]        aw_burst;

  rr_picker #(.N(NUM_REQ), .PTR_W(PTR_W)) u_wr_pick (
    .req(req.awvalid), .ptr(rr_wr), .gnt_idx(wr_gnt), .any(wr_any)
  );

  assign aw_hs  = (wr_state == WR_ADDR) && s_axi.awready[0];
  assign w_done = (wr_state == WR_DATA) && req.wvalid[wr_own] && s_axi.wready[0] && req.wlast[wr_own];
  assign b_done = (wr_state == WR_RESP) && s_axi.bvalid[0] && req.bready[wr_own];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_nxt;
  end

  always_comb begin
    wr_nxt = wr_state;
    unique case (wr_state)
      WR_IDLE: if (wr_any) wr_nxt = WR_ADDR;
      WR_ADDR: if (aw_hs)  wr_nxt = WR_DATA;
      WR_DATA: if (w_done) wr_nxt = WR_RESP;
      WR_RESP: if (b_done) wr_nxt = WR_IDLE;
      default: wr_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_wr    <= '0;
      wr_own   <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_burst <= '0;
    end else begin
      if (wr_state == WR_IDLE && wr_any) begin
        wr_own   <= wr_gnt;
        aw_addr  <= req.awaddr[int'(wr_gnt)*ADDR_W +: ADDR_W];
        aw_len   <= req.awlen[int'(wr_gnt)*8 +: 8];
        aw_burst <= req.awburst[int'(wr_gnt)*2 +: 2];
      end
      if (b_done) rr_wr <= ptr_inc(wr_own);
    end
  end

  // W payload follows the owner; only valid/ready are gated by state.
  always_comb begin
    s_axi.awvalid = '0;
    s_axi.awaddr  = aw_addr;
    s_axi.awlen   = aw_len;
    s_axi.awburst = aw_burst;
    s_axi.wvalid  = '0;
    s_axi.wlast   = '0;
    s_axi.wdata   = req.wdata[int'(wr_own)*DATA_W +: DATA_W];
    s_axi.wstrb   = req.wstrb[int'(wr_own)*STRB_W +: STRB_W];
    s_axi.bready  = '0;
    req.awready   = '0;
    req.wready    = '0;
    req.bvalid    = '0;
    req.bresp     = s_axi.bresp;
    unique case (wr_state)
      WR_ADDR: begin
        s_axi.awvalid       = 1'b1;
        req.awready[wr_own] = s_axi.awready[0];
      end
      WR_DATA: begin
        s_axi.wvalid[0]    = req.wvalid[wr_own];
        s_axi.wlast[0]     = req.wlast[wr_own];
        req.wready[wr_own] = s_axi.wready[0];
      end
      WR_RESP: begin
        req.bvalid[wr_own] = s_axi.bvalid[0];
        s_axi.bready[0]    = req.bready[wr_own];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_axi_wrapper_arbiter.sv
// Directed bench for axi_wrapper_arbiter: two requesters, bench plays the downstream slave.
module tb_axi_wrapper_arbiter;
  import axi_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [3:0] arcache, awcache;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  axi_wrapper_arbiter_if #(.N(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_bus ();
  axi_wrapper_arbiter_if #(.N(1), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_bus ();

  axi_wrapper_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .req(req_bus), .s_axi(s_bus),
    .s_axi_arsize(arsize), .s_axi_awsize(awsize),
    .s_axi_arcache(arcache), .s_axi_awcache(awcache),
    .s_axi_arprot(arprot), .s_axi_awprot(awprot)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    req_bus.arvalid = '0; req_bus.araddr = '0; req_bus.arlen = '0; req_bus.arburst = '0;
    req_bus.rready  = '0;
    req_bus.awvalid = '0; req_bus.awaddr = '0; req_bus.awlen = '0; req_bus.awburst = '0;
    req_bus.wvalid  = '0; req_bus.wdata  = '0; req_bus.wstrb = '0; req_bus.wlast   = '0;
    req_bus.bready  = '0;
    s_bus.arready = '0; s_bus.rvalid = '0; s_bus.rlast = '0; s_bus.rdata = '0; s_bus.rresp = '0;
    s_bus.awready = '0; s_bus.wready = '0; s_bus.bvalid = '0; s_bus.bresp = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    repeat (2) @(negedge clock);
    n_checks++; if (s_bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_s_arvalid: got %0h want 0", s_bus.arvalid); end
    n_checks++; if (s_bus.awvalid !== 1'b0) begin n_fail++; $display("FAIL rst_s_awvalid: got %0h want 0", s_bus.awvalid); end
    n_checks++; if (s_bus.araddr !== 32'h0) begin n_fail++; $display("FAIL rst_s_araddr: got %0h want 0", s_bus.araddr); end
    n_checks++; if (dut.rd_state !== RD_IDLE) begin n_fail++; $display("FAIL rst_rd_state: got %0d want RD_IDLE", dut.rd_state); end
    n_checks++; if (dut.wr_state !== WR_IDLE) begin n_fail++; $display("FAIL rst_wr_state: got %0d want WR_IDLE", dut.wr_state); end
    n_checks++; if (arsize !== 3'd2) begin n_fail++; $display("FAIL rst_arsize: got %0d want 2", arsize); end
    n_checks++; if (awcache !== 4'b0011) begin n_fail++; $display("FAIL rst_awcache: got %0h want 3", awcache); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    req_bus.arvalid = 2'b01;
    req_bus.araddr[31:0] = 32'h8000_0000;
    req_bus.arlen[7:0]   = 8'd3;
    req_bus.arburst[1:0] = AXI_BURST_INCR;
    #1;
    n_checks++; if (s_bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL sr_arvalid_early: got %0h want 0", s_bus.arvalid); end
    @(negedge clock);
    n_checks++; if (s_bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL sr_arvalid: got %0h want 1", s_bus.arvalid); end
    n_checks++; if (s_bus.araddr !== 32'h8000_0000) begin n_fail++; $display("FAIL sr_araddr: got %0h want 80000000", s_bus.araddr); end
    n_checks++; if (s_bus.arlen !== 8'd3) begin n_fail++; $display("FAIL sr_arlen: got %0d want 3", s_bus.arlen); end
    n_checks++; if (req_bus.arready !== 2'b00) begin n_fail++; $display("FAIL sr_arready_wait: got %b want 00", req_bus.arready); end
    s_bus.arready = 1'b1;
    #1;
    n_checks++; if (req_bus.arready !== 2'b01) begin n_fail++; $display("FAIL sr_arready_pulse: got %b want 01", req_bus.arready); end
    @(negedge clock);
    req_bus.arvalid = 2'b00;
    s_bus.arready = 1'b0;
    #1;
    n_checks++; if (s_bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL sr_arvalid_drop: got %0h want 0", s_bus.arvalid); end
    req_bus.rready = 2'b01;
    for (int b = 0; b < 4; b++) begin
      s_bus.rvalid = 1'b1;
      s_bus.rdata  = 32'hA0 + 32'(b);
      s_bus.rlast  = (b == 3);
      #1;
      n_checks++; if (req_bus.rvalid !== 2'b01) begin n_fail++; $display("FAIL sr_rvalid beat %0d: got %b want 01", b, req_bus.rvalid); end
      n_checks++; if (req_bus.rdata !== 32'hA0 + 32'(b)) begin n_fail++; $display("FAIL sr_rdata beat %0d: got %0h want %0h", b, req_bus.rdata, 32'hA0 + b); end
      n_checks++; if (req_bus.rlast !== ((b == 3) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL sr_rlast beat %0d: got %b", b, req_bus.rlast); end
      @(negedge clock);
    end
    s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0; req_bus.rready = 2'b00;
    n_checks++; if (dut.rd_state !== RD_IDLE) begin n_fail++; $display("FAIL sr_idle: got %0d want RD_IDLE", dut.rd_state); end
    n_checks++; if (dut.rr_rd !== 1'b1) begin n_fail++; $display("FAIL sr_rr_rd: got %0d want 1", dut.rr_rd); end
  endtask

  // Plain one-requester read used to steer the round-robin pointer.
  task automatic read_burst(input int who, input logic [31:0] addr, input int beats);
    logic [1:0] oh;
    oh = 2'b01 << who;
    req_bus.arvalid = oh;
    req_bus.araddr[who*32 +: 32] = addr;
    req_bus.arlen[who*8 +: 8] = 8'(beats - 1);
    @(negedge clock);
    n_checks++; if (s_bus.araddr !== addr) begin n_fail++; $display("FAIL rb_araddr: got %0h want %0h", s_bus.araddr, addr); end
    s_bus.arready = 1'b1;
    @(negedge clock);
    s_bus.arready = 1'b0; req_bus.arvalid = 2'b00; req_bus.rready = oh;
    for (int b = 0; b < beats; b++) begin
      s_bus.rvalid = 1'b1; s_bus.rlast = (b == beats - 1); s_bus.rdata = 32'(b);
      #1;
      n_checks++; if (req_bus.rvalid !== oh) begin n_fail++; $display("FAIL rb_rvalid: got %b want %b", req_bus.rvalid, oh); end
      @(negedge clock);
    end
    s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0; req_bus.rready = 2'b00;
  endtask

  task automatic test_contention(input int first);
    logic [1:0]  oh_f, oh_s;
    logic [31:0] a_f, a_s;
    oh_f = 2'b01 << first;
    oh_s = 2'b01 << (1 - first);
    a_f  = (first == 0) ? 32'h1000_0000 : 32'h2000_0000;
    a_s  = (first == 0) ? 32'h2000_0000 : 32'h1000_0000;
    req_bus.arvalid = 2'b11;
    req_bus.araddr  = {32'h2000_0000, 32'h1000_0000};
    req_bus.arlen   = '0;
    @(negedge clock);
    n_checks++; if (s_bus.araddr !== a_f) begin n_fail++; $display("FAIL ct%0d_first_addr: got %0h want %0h", first, s_bus.araddr, a_f); end
    s_bus.arready = 1'b1;
    #1;
    n_checks++; if (req_bus.arready !== oh_f) begin n_fail++; $display("FAIL ct%0d_first_arready: got %b want %b", first, req_bus.arready, oh_f); end
    @(negedge clock);
    s_bus.arready = 1'b0; req_bus.arvalid = oh_s;
    s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; req_bus.rready = 2'b11;
    #1;
    n_checks++; if (req_bus.rvalid !== oh_f) begin n_fail++; $display("FAIL ct%0d_first_rvalid: got %b want %b", first, req_bus.rvalid, oh_f); end
    @(negedge clock);
    s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0;
    #1;
    n_checks++; if (s_bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL ct%0d_idle_gap: got %0h want 0", first, s_bus.arvalid); end
    @(negedge clock);
    n_checks++; if (s_bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL ct%0d_second_arvalid: got %0h want 1", first, s_bus.arvalid); end
    n_checks++; if (s_bus.araddr !== a_s) begin n_fail++; $display("FAIL ct%0d_second_addr: got %0h want %0h", first, s_bus.araddr, a_s); end
    s_bus.arready = 1'b1;
    #1;
    n_checks++; if (req_bus.arready !== oh_s) begin n_fail++; $display("FAIL ct%0d_second_arready: got %b want %b", first, req_bus.arready, oh_s); end
    @(negedge clock);
    s_bus.arready = 1'b0; req_bus.arvalid = 2'b00;
    s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1;
    #1;
    n_checks++; if (req_bus.rvalid !== oh_s) begin n_fail++; $display("FAIL ct%0d_second_rvalid: got %b want %b", first, req_bus.rvalid, oh_s); end
    @(negedge clock);
    s_bus.rvalid = 1'b0; s_bus.rlast = 1'b0; req_bus.rready = 2'b00;
  endtask

  task automatic test_full_duplex();
    req_bus.arvalid = 2'b01; req_bus.araddr[31:0] = 32'h3000_0000; req_bus.arlen[7:0] = 8'd7;
    req_bus.awvalid = 2'b10; req_bus.awaddr[63:32] = 32'h4000_0000; req_bus.awlen[15:8] = 8'd1;
    req_bus.awburst[3:2] = AXI_BURST_INCR;
    @(negedge clock);
    n_checks++; if (s_bus.arvalid !== 1'b1 || s_bus.awvalid !== 1'b1) begin n_fail++; $display("FAIL fd_both_valid: got ar=%0h aw=%0h want 1/1", s_bus.arvalid, s_bus.awvalid); end
    n_checks++; if (s_bus.awaddr !== 32'h4000_0000) begin n_fail++; $display("FAIL fd_awaddr: got %0h want 40000000", s_bus.awaddr); end
    n_checks++; if (s_bus.awlen !== 8'd1) begin n_fail++; $display("FAIL fd_awlen: got %0d want 1", s_bus.awlen); end
    s_bus.arready = 1'b1; s_bus.awready = 1'b1;
    #1;
    n_checks++; if (req_bus.awready !== 2'b10) begin n_fail++; $display("FAIL fd_awready: got %b want 10", req_bus.awready); end
    @(negedge clock);
    req_bus.arvalid = 2'b00; req_bus.awvalid = 2'b00; s_bus.arready = 1'b0; s_bus.awready = 1'b0;
    req_bus.rready = 2'b01; req_bus.bready = 2'b10; s_bus.wready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_bus.rvalid = 1'b1; s_bus.rdata = 32'h300 + 32'(i); s_bus.rlast = (i == 7);
      req_bus.wvalid = (i < 2) ? 2'b10 : 2'b00;
      req_bus.wdata[63:32] = 32'h5000 + 32'(i);
      req_bus.wstrb[7:4] = 4'hF;
      req_bus.wlast = (i == 1) ? 2'b10 : 2'b00;
      s_bus.bvalid = (i == 2); s_bus.bresp = AXI_RESP_OKAY;
      #1;
      n_checks++; if (req_bus.rvalid !== 2'b01) begin n_fail++; $display("FAIL fd_rvalid beat %0d: got %b want 01", i, req_bus.rvalid); end
      if (i < 2) begin
        n_checks++; if (s_bus.wvalid !== 1'b1 || s_bus.wdata !== 32'h5000 + 32'(i)) begin n_fail++; $display("FAIL fd_w beat %0d: got v=%0h d=%0h", i, s_bus.wvalid, s_bus.wdata); end
        n_checks++; if (s_bus.wstrb !== 4'hF || req_bus.wready !== 2'b10) begin n_fail++; $display("FAIL fd_wstrb_ready beat %0d: got s=%0h r=%b want F/10", i, s_bus.wstrb, req_bus.wready); end
        n_checks++; if (s_bus.wlast !== ((i == 1) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL fd_wlast beat %0d: got %0h", i, s_bus.wlast); end
      end
      if (i == 2) begin
        n_checks++; if (req_bus.bvalid !== 2'b10) begin n_fail++; $display("FAIL fd_bvalid: got %b want 10", req_bus.bvalid); end
        n_checks++; if (req_bus.bresp !== AXI_RESP_OKAY || s_bus.bready !== 1'b1) begin n_fail++; $display("FAIL fd_bresp_bready: got %0h/%0h want 0/1", req_bus.bresp, s_bus.bready); end
        n_checks++; if (req_bus.wready !== 2'b00) begin n_fail++; $display("FAIL fd_wready_resp: got %b want 00", req_bus.wready); end
      end
      if (i == 3) begin
        n_checks++; if (dut.wr_state !== WR_IDLE) begin n_fail++; $display("FAIL fd_wr_idle: got %0d want WR_IDLE", dut.wr_state); end
      end
      @(negedge clock);
    end
    clear_inputs();
    n_checks++; if (dut.rd_state !== RD_IDLE) begin n_fail++; $display("FAIL fd_rd_idle: got %0d want RD_IDLE", dut.rd_state); end
  endtask

  task automatic test_w_gating();
    req_bus.wvalid = 2'b10; req_bus.wdata[63:32] = 32'hBEEF; req_bus.wstrb[7:4] = 4'hF; req_bus.wlast = 2'b10;
    s_bus.wready = 1'b1;
    #1;
    n_checks++; if (req_bus.wready !== 2'b00 || s_bus.wvalid !== 1'b0) begin n_fail++; $display("FAIL wg_idle: got wready=%b s_wvalid=%0h want 00/0", req_bus.wready, s_bus.wvalid); end
    @(negedge clock);
    req_bus.awvalid = 2'b10; req_bus.awaddr[63:32] = 32'h6000_0000; req_bus.awlen[15:8] = 8'd0;
    @(negedge clock);
    n_checks++; if (s_bus.awvalid !== 1'b1) begin n_fail++; $display("FAIL wg_awvalid: got %0h want 1", s_bus.awvalid); end
    n_checks++; if (req_bus.wready !== 2'b00 || s_bus.wvalid !== 1'b0) begin n_fail++; $display("FAIL wg_addr: got wready=%b s_wvalid=%0h want 00/0", req_bus.wready, s_bus.wvalid); end
    s_bus.awready = 1'b1;
    #1;
    n_checks++; if (req_bus.awready !== 2'b10 || req_bus.wready !== 2'b00) begin n_fail++; $display("FAIL wg_aw_hs: got awready=%b wready=%b want 10/00", req_bus.awready, req_bus.wready); end
    @(negedge clock);
    req_bus.awvalid = 2'b00; s_bus.awready = 1'b0;
    #1;
    n_checks++; if (s_bus.wvalid !== 1'b1 || req_bus.wready !== 2'b10) begin n_fail++; $display("FAIL wg_data: got s_wvalid=%0h wready=%b want 1/10", s_bus.wvalid, req_bus.wready); end
    n_checks++; if (s_bus.wdata !== 32'hBEEF) begin n_fail++; $display("FAIL wg_wdata: got %0h want beef", s_bus.wdata); end
    @(negedge clock);
    req_bus.wvalid = 2'b00; req_bus.wlast = 2'b00;
    s_bus.bvalid = 1'b1; req_bus.bready = 2'b10;
    #1;
    n_checks++; if (req_bus.bvalid !== 2'b10 || req_bus.wready !== 2'b00) begin n_fail++; $display("FAIL wg_resp: got bvalid=%b wready=%b want 10/00", req_bus.bvalid, req_bus.wready); end
    @(negedge clock);
    clear_inputs();
    n_checks++; if (dut.wr_state !== WR_IDLE) begin n_fail++; $display("FAIL wg_wr_idle: got %0d want WR_IDLE", dut.wr_state); end
  endtask

  task automatic test_backpressure();
    logic [5:0] pat;
    int beat;
    pat  = 6'b111001;
    beat = 0;
    req_bus.arvalid = 2'b01; req_bus.araddr[31:0] = 32'h7000_0000; req_bus.arlen[7:0] = 8'd3;
    @(negedge clock);
    s_bus.arready = 1'b1;
    @(negedge clock);
    s_bus.arready = 1'b0; req_bus.arvalid = 2'b00;
    for (int c = 0; c < 6; c++) begin
      s_bus.rvalid = 1'b1; s_bus.rdata = 32'h200 + 32'(beat); s_bus.rlast = (beat == 3);
      req_bus.rready = {1'b0, pat[c]};
      #1;
      n_checks++; if (s_bus.rready !== pat[c]) begin n_fail++; $display("FAIL bp_rready cyc %0d: got %0h want %0h", c, s_bus.rready, pat[c]); end
      n_checks++; if (req_bus.rvalid !== 2'b01 || req_bus.rdata !== 32'h200 + 32'(beat)) begin n_fail++; $display("FAIL bp_beat cyc %0d: got v=%b d=%0h want 01/%0h", c, req_bus.rvalid, req_bus.rdata, 32'h200 + beat); end
      @(negedge clock);
      if (pat[c]) beat++;
    end
    clear_inputs();
    n_checks++; if (dut.rd_state !== RD_IDLE) begin n_fail++; $display("FAIL bp_idle: got %0d want RD_IDLE", dut.rd_state); end
  endtask

  task automatic test_reset_mid_burst();
    req_bus.arvalid = 2'b01; req_bus.araddr[31:0] = 32'h8800_0000; req_bus.arlen[7:0] = 8'd3;
    @(negedge clock);
    s_bus.arready = 1'b1;
    @(negedge clock);
    s_bus.arready = 1'b0; req_bus.arvalid = 2'b00;
    req_bus.rready = 2'b01; s_bus.rvalid = 1'b1; s_bus.rlast = 1'b0;
    @(negedge clock);
    #1;
    n_checks++; if (req_bus.rvalid !== 2'b01) begin n_fail++; $display("FAIL rm_beat2: got %b want 01", req_bus.rvalid); end
    reset = 1'b1;
    #1;
    n_checks++; if (s_bus.arvalid !== 1'b0 || s_bus.awvalid !== 1'b0 || s_bus.rready !== 1'b0) begin n_fail++; $display("FAIL rm_s_valids: got ar=%0h aw=%0h rr=%0h want 0", s_bus.arvalid, s_bus.awvalid, s_bus.rready); end
    n_checks++; if (req_bus.rvalid !== 2'b00) begin n_fail++; $display("FAIL rm_req_rvalid: got %b want 00", req_bus.rvalid); end
    n_checks++; if (dut.rd_state !== RD_IDLE || dut.wr_state !== WR_IDLE) begin n_fail++; $display("FAIL rm_states: got rd=%0d wr=%0d want idle", dut.rd_state, dut.wr_state); end
    n_checks++; if (dut.rr_rd !== 1'b0 || dut.rr_wr !== 1'b0) begin n_fail++; $display("FAIL rm_rr: got rd=%0d wr=%0d want 0", dut.rr_rd, dut.rr_wr); end
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
    req_bus.arvalid = 2'b10; req_bus.araddr[63:32] = 32'h9000_0000; req_bus.arlen[15:8] = 8'd0;
    #1;
    n_checks++; if (s_bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL rm_new_early: got %0h want 0", s_bus.arvalid); end
    @(negedge clock);
    n_checks++; if (s_bus.arvalid !== 1'b1 || s_bus.araddr !== 32'h9000_0000) begin n_fail++; $display("FAIL rm_new_ar: got v=%0h a=%0h want 1/90000000", s_bus.arvalid, s_bus.araddr); end
    s_bus.arready = 1'b1;
    #1;
    n_checks++; if (req_bus.arready !== 2'b10) begin n_fail++; $display("FAIL rm_new_arready: got %b want 10", req_bus.arready); end
    @(negedge clock);
    s_bus.arready = 1'b0; req_bus.arvalid = 2'b00;
    s_bus.rvalid = 1'b1; s_bus.rlast = 1'b1; req_bus.rready = 2'b10;
    #1;
    n_checks++; if (req_bus.rvalid !== 2'b10) begin n_fail++; $display("FAIL rm_new_rvalid: got %b want 10", req_bus.rvalid); end
    @(negedge clock);
    clear_inputs();
    n_checks++; if (dut.rd_state !== RD_IDLE || dut.rr_rd !== 1'b0) begin n_fail++; $display("FAIL rm_new_done: got st=%0d rr=%0d want idle/0", dut.rd_state, dut.rr_rd); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention(1);
    read_burst(1, 32'h0000_1000, 1);
    test_contention(0);
    test_full_duplex();
    test_w_gating();
    test_backpressure();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
